video_crop_window: RTL

Pixel-qualification stage directly upstream of the line buffer. It counts pixels per line and lines per frame from the core's raw video stream, and asserts `disable_pix` for every pixel outside a programmable crop window, so the line buffer stores only active, un-overscanned pixels. It also reports the measured line width and frame height of the previous line and frame for status and debug. All outputs are delayed by one register stage so they stay aligned with each other.

---
 rtl/video_crop_window.sv | 135 +++++++++++++
 1 files changed

// File: rtl/video_crop_window.sv
// Pixel qualifier for the line buffer: counts pixels/lines from raw syncs and flags
// pixels outside a frame-latched crop window. All outputs are one register stage late.
module video_crop_window #(
    parameter int H_CNT_W = 10,
    parameter int V_CNT_W = 9
) (
    input  logic               clk_vid,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [23:0]        rgb_in,
    input  logic               crop_enable,
    input  logic [H_CNT_W-1:0] h_start,
    input  logic [H_CNT_W-1:0] h_width,
    input  logic [V_CNT_W-1:0] v_start,
    input  logic [V_CNT_W-1:0] v_height,
    output logic               ce_pix_out,
    output logic               disable_pix,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [23:0]        rgb_out,
    output logic [H_CNT_W-1:0] line_pixels,
    output logic [V_CNT_W-1:0] frame_lines
);

    localparam logic [H_CNT_W-1:0] H_ZERO = {H_CNT_W{1'b0}};
    localparam logic [H_CNT_W-1:0] H_ONE  = {{(H_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [H_CNT_W-1:0] H_MAX  = {H_CNT_W{1'b1}};
    localparam logic [V_CNT_W-1:0] V_ZERO = {V_CNT_W{1'b0}};
    localparam logic [V_CNT_W-1:0] V_ONE  = {{(V_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [V_CNT_W-1:0] V_MAX  = {V_CNT_W{1'b1}};

    logic               prev_hs_q, prev_vs_q;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [H_CNT_W-1:0] line_pixels_d;
    logic [V_CNT_W-1:0] frame_lines_d;
    logic               crop_en_q, crop_en_d;
    logic [H_CNT_W-1:0] h_start_q, h_start_d, h_width_q, h_width_d;
    logic [V_CNT_W-1:0] v_start_q, v_start_d, v_height_q, v_height_d;

    logic               hs_edge_s, vs_edge_s, visible_s, disable_d;
    logic [H_CNT_W-1:0] hidx_s;
    logic [H_CNT_W:0]   h_end_s;
    logic [V_CNT_W:0]   v_end_s;

    // Edge detect, counters, status latches, config shadows and window test.
    always_comb begin
        hs_edge_s = hsync_in & ~prev_hs_q;
        vs_edge_s = vsync_in & ~prev_vs_q;
        hidx_s    = hs_edge_s ? H_ZERO : h_cnt_q;

        if (hs_edge_s) begin
            h_cnt_d = ce_pix ? H_ONE : H_ZERO;
        end else if (ce_pix && (h_cnt_q != H_MAX)) begin
            h_cnt_d = h_cnt_q + H_ONE;
        end else begin
            h_cnt_d = h_cnt_q;
        end

        // vsync wins over a coincident hsync, so the new frame starts at line 0.
        if (vs_edge_s) begin
            v_cnt_d = V_ZERO;
        end else if (hs_edge_s && (v_cnt_q != V_MAX)) begin
            v_cnt_d = v_cnt_q + V_ONE;
        end else begin
            v_cnt_d = v_cnt_q;
        end

        line_pixels_d = hs_edge_s ? h_cnt_q : line_pixels;
        frame_lines_d = vs_edge_s ? v_cnt_q : frame_lines;

        if (vs_edge_s) begin
            crop_en_d  = crop_enable;
            h_start_d  = h_start;
            h_width_d  = h_width;
            v_start_d  = v_start;
            v_height_d = v_height;
        end else begin
            crop_en_d  = crop_en_q;
            h_start_d  = h_start_q;
            h_width_d  = h_width_q;
            v_start_d  = v_start_q;
            v_height_d = v_height_q;
        end

        // Sums carry an extra bit so a window reaching past the counter range never wraps.
        h_end_s   = {1'b0, h_start_d} + {1'b0, h_width_d};
        v_end_s   = {1'b0, v_start_d} + {1'b0, v_height_d};
        visible_s = (hidx_s >= h_start_d) && ({1'b0, hidx_s} < h_end_s) &&
                    (v_cnt_d >= v_start_d) && ({1'b0, v_cnt_d} < v_end_s);
        disable_d = ce_pix & crop_en_d & ~visible_s;
    end

    // State and output registers.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            prev_hs_q   <= 1'b0;
            prev_vs_q   <= 1'b0;
            h_cnt_q     <= H_ZERO;
            v_cnt_q     <= V_ZERO;
            crop_en_q   <= 1'b0;
            h_start_q   <= H_ZERO;
            h_width_q   <= H_ZERO;
            v_start_q   <= V_ZERO;
            v_height_q  <= V_ZERO;
            line_pixels <= H_ZERO;
            frame_lines <= V_ZERO;
            ce_pix_out  <= 1'b0;
            disable_pix <= 1'b0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            rgb_out     <= 24'h000000;
        end else begin
            prev_hs_q   <= hsync_in;
            prev_vs_q   <= vsync_in;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            crop_en_q   <= crop_en_d;
            h_start_q   <= h_start_d;
            h_width_q   <= h_width_d;
            v_start_q   <= v_start_d;
            v_height_q  <= v_height_d;
            line_pixels <= line_pixels_d;
            frame_lines <= frame_lines_d;
            ce_pix_out  <= ce_pix;
            disable_pix <= disable_d;
            hsync_out   <= hsync_in;
            vsync_out   <= vsync_in;
            rgb_out     <= rgb_in;
        end
    end

endmodule
